// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready stage register with a 2-entry skid buffer and flush.
// Define PIPE_STAGE_STATS_EN to add the stall_cnt/flush_cnt outputs.
module pipe_stage_skid #(
   parameter int                   PAYLOAD_W = 203,
   parameter logic [PAYLOAD_W-1:0] KILL_MASK = {PAYLOAD_W{1'b0}},
   parameter logic [PAYLOAD_W-1:0] RESET_VAL = {PAYLOAD_W{1'b0}}
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   input  logic                 flush,
   output logic [1:0]           occupancy
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [31:0]          stall_cnt,
   output logic [31:0]          flush_cnt
`endif
);

   // encoding doubles as the entry count
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PAYLOAD_W-1:0] r_main;
   logic [PAYLOAD_W-1:0] r_skid;
   logic [PAYLOAD_W-1:0] w_main_nxt;
   logic [PAYLOAD_W-1:0] w_skid_nxt;
   logic                 w_in_xfer;
   logic                 w_out_xfer;

   assign in_ready   = (r_state != S_FULL);
   assign out_valid  = (r_state != S_EMPTY);
   assign out_data   = r_main;
   assign occupancy  = r_state;
   assign w_in_xfer  = in_valid & in_ready & ~flush;
   assign w_out_xfer = out_valid & out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      unique case (r_state)
         S_EMPTY: begin
            if (w_in_xfer) begin
               w_main_nxt  = in_data;
               w_state_nxt = S_ONE;
            end
         end
         S_ONE: begin
            if (w_in_xfer && w_out_xfer) begin
               w_main_nxt = in_data;
            end else if (w_in_xfer) begin
               w_skid_nxt  = in_data;
               w_state_nxt = S_FULL;
            end else if (w_out_xfer) begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            if (w_out_xfer) begin
               w_main_nxt  = r_skid;
               w_state_nxt = S_ONE;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
      // the consumed head is already gone; kill what remains
      if (flush) begin
         w_state_nxt = S_EMPTY;
         w_main_nxt  = w_main_nxt & ~KILL_MASK;
         w_skid_nxt  = r_skid & ~KILL_MASK;
      end
   end

   always_ff @(negedge clk) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
         r_main  <= RESET_VAL;
         r_skid  <= RESET_VAL;
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(negedge clk) begin
      if (!rst_n) begin
         r_stall_cnt <= 32'd0;
         r_flush_cnt <= 32'd0;
      end else begin
         if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (flush && (r_flush_cnt != 32'hFFFF_FFFF))
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: randomized + directed check of pipe_stage_skid
// against a queue-based FIFO reference model.
module tb_pipe_stage_skid;
   localparam int          W  = 32;
   localparam logic [W-1:0] KM = 32'h0000_003F;
   localparam logic [W-1:0] RV = 32'hA5A5_5A5A;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         flush;
   logic [1:0]   occupancy;
`ifdef PIPE_STAGE_STATS_EN
   logic [31:0]  stall_cnt;
   logic [31:0]  flush_cnt;
`endif

   pipe_stage_skid #(
      .PAYLOAD_W (W),
      .KILL_MASK (KM),
      .RESET_VAL (RV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference: a FIFO of at most two entries plus the last known head value
   logic [W-1:0] q[$];
   logic [W-1:0] m_dval;
   logic [W-1:0] m_dmask;
   bit           m_init = 0;
   bit           last_acc;
   int           delivered = 0;
`ifdef PIPE_STAGE_STATS_EN
   logic [31:0]  m_stall = 0;
   logic [31:0]  m_flush = 0;
`endif

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      if (!m_init) return;
      chk("occ", 64'(occupancy), 64'(q.size()));
      chk("ovalid", 64'(out_valid), 64'(q.size() != 0));
      chk("iready", 64'(in_ready), 64'(q.size() < 2));
      if (m_dmask != '0)
         chk("odata", 64'(out_data & m_dmask), 64'(m_dval & m_dmask));
`ifdef PIPE_STAGE_STATS_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
   endtask

   task automatic step(input logic v, input logic [W-1:0] d,
                       input logic ordy, input logic fl, input logic rn);
      int  sz;
      bit  ox;
      bit  ix;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      rst_n     = rn;
      check_outputs();
      sz = q.size();
      ox = (sz > 0) && ordy;
      ix = v && (sz < 2) && !fl;
      last_acc = 0;
      @(negedge clk);
      if (!rn) begin
         q.delete();
         m_dval  = RV;
         m_dmask = '1;
         m_init  = 1;
`ifdef PIPE_STAGE_STATS_EN
         m_stall = 0;
         m_flush = 0;
`endif
      end else begin
`ifdef PIPE_STAGE_STATS_EN
         if (sz > 0 && !ordy && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (fl && m_flush != 32'hFFFF_FFFF) m_flush++;
`endif
         if (ox) begin
            void'(q.pop_front());
            delivered++;
         end
         if (fl) begin
            q.delete();
            m_dval  = '0;
            m_dmask = KM;
         end else if (ix) begin
            q.push_back(d);
            last_acc = 1;
         end
         if (q.size() > 0) begin
            m_dval  = q[0];
            m_dmask = '1;
         end else if (ox && !fl) begin
            m_dmask = '0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0] items[3];
   int           ptr;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; flush = 1'b0;
      m_dval = '0; m_dmask = '0;
      @(posedge clk);
      #1;
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 0, 0);

      // reset while FULL
      step(1, 32'h1111_0001, 0, 0, 1);
      step(1, 32'h2222_0002, 0, 0, 1);
      chk("preload_occ", 64'(occupancy), 64'd2);
      step(1, 32'h3333_0003, 1, 0, 0);
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_oval", 64'(out_valid), 64'd0);
      chk("rst_irdy", 64'(in_ready), 64'd1);
      chk("rst_data", 64'(out_data), 64'(RV));

      // streaming 1..100
      for (int i = 1; i <= 100; i++) step(1, W'(i), 1, 0, 1);
      step(0, '0, 1, 0, 1);
      step(0, '0, 1, 0, 1);

      // stall / skid
      items[0] = 32'hAAAA_000A;
      items[1] = 32'hBBBB_000B;
      items[2] = 32'hCCCC_000C;
      ptr = 0;
      for (int i = 0; i < 5; i++) begin
         step(ptr < 3, items[ptr < 3 ? ptr : 0], 0, 0, 1);
         if (last_acc) ptr++;
      end
      chk("skid_occ", 64'(occupancy), 64'd2);
      chk("skid_irdy", 64'(in_ready), 64'd0);
      chk("skid_head", 64'(out_data), 64'(items[0]));
      for (int i = 0; i < 10; i++) begin
         step(ptr < 3, items[ptr < 3 ? ptr : 0], 1, 0, 1);
         if (last_acc) ptr++;
      end
      chk("skid_drained", 64'(occupancy), 64'd0);

      // flush while FULL with new input present
      step(1, 32'h1234_563F, 0, 0, 1);
      step(1, 32'h89AB_CD3F, 0, 0, 1);
      step(1, 32'hDEAD_BEEF, 0, 1, 1);
      chk("flush_occ", 64'(occupancy), 64'd0);
      chk("flush_oval", 64'(out_valid), 64'd0);
      chk("flush_ctl", 64'(out_data & KM), 64'd0);
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 1);

      // flush + out_ready in ONE
      step(1, 32'h5555_0015, 0, 0, 1);
      chk("fo_head", 64'(out_data), 64'h5555_0015);
      step(0, '0, 1, 1, 1);
      chk("fo_occ", 64'(occupancy), 64'd0);

`ifdef PIPE_STAGE_STATS_EN
      step(0, '0, 0, 0, 0);
      step(1, 32'h0000_0777, 0, 0, 1);
      for (int i = 0; i < 7; i++) step(0, '0, 0, 0, 1);
      step(0, '0, 1, 1, 1);
      step(0, '0, 0, 1, 1);
      chk("stats_stall7", 64'(stall_cnt), 64'd7);
      chk("stats_flush2", 64'(flush_cnt), 64'd2);
      step(1, 32'h0000_0888, 0, 0, 1);
      dut.r_stall_cnt = 32'hFFFF_FFFE;
      m_stall = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
      chk("stats_sat", 64'(stall_cnt), 64'hFFFF_FFFF);
`endif

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 10) < 7, W'($urandom),
              ($urandom % 10) < 6,
              ($urandom % 16) == 0,
              ($urandom % 64) != 0);
      end
      step(0, '0, 1, 0, 1);
      check_outputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register; successor to the fixed-field EX/MEM latch.
- Carries an arbitrary-width payload between two pipeline stages using a valid/ready handshake.
- Includes a 2-entry skid buffer, so a downstream stall (e.g. a cache miss) never drops data and never creates a combinational ready path.
- Supports flush with bubble insertion: selected control bits are killed. Instantiated between EX/MEM and MEM/WB, and anywhere else a stallable stage boundary is needed.

Parameters:
- PAYLOAD_W, 203, payload width in bits. Default packs branchTarget 64 + ALUResult 64 + readData2 64 + writeReg 5 + 6 control bits.
- KILL_MASK, {PAYLOAD_W{1'b0}}, bits set here are forced to 0 in any entry invalidated by flush (control bits such as MemWrite/RegWrite).
- RESET_VAL, {PAYLOAD_W{1'b0}}, value loaded into both storage entries at reset.

Ports:
- clk  in  1  stage clock; all state updates on falling edge (pipeline convention).
- rst_n  in  1  synchronous active-low reset, sampled on falling edge of clk.
- in_valid  in  1  upstream presents valid payload.
- in_ready  out  1  stage can accept; registered, depends only on internal state.
- in_data  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream accepts (drive from cache hit).
- out_data  out  PAYLOAD_W  head-entry payload; registered.
- flush  in  1  discard all held entries and any same-edge input.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main entry (drives out_data) and skid entry, each with a valid bit.
- States: EMPTY (occ 0), ONE (main valid), FULL (main+skid valid).
- Handshakes: a transfer happens on an edge when valid and ready are both 1 on that side. in_ready = (state != FULL).
- EMPTY: input xfer -> main := in_data, go ONE.
- ONE, output xfer only -> EMPTY.
- ONE, input only -> skid := in_data, go FULL.
- ONE, both xfers -> main := in_data, stay ONE.
- ONE, neither -> hold.
- FULL: output xfer -> main := skid, go ONE; otherwise hold. No input xfer is possible in FULL.
- Latency: 1 edge from accept to out_valid when EMPTY. Throughput 1 entry per edge while out_ready stays 1.
- Order: strictly FIFO; no entry is duplicated or dropped.
- Hold: out_data stays stable while out_valid=1 and out_ready=0.
- flush=1 (priority over everything except reset):
  - Next state EMPTY.
  - Same-edge input is discarded even if in_valid=1; in_ready still reads its pre-edge value.
  - Payload of both entries is ANDed with ~KILL_MASK. Other bits are unchanged so waveforms remain debuggable.
  - out_valid=0 next edge.
- Simultaneous flush and out_ready: the downstream sees the pre-edge entry consumed. The flush applies to the remaining entries.
- Reset (rst_n=0 at edge, including mid-transfer or while FULL):
  - Both valids 0 and both entries := RESET_VAL.
  - After the edge: in_ready=1, out_valid=0, out_data=RESET_VAL, occupancy=0.
  - Reset overrides flush and handshakes.
- occupancy = main_valid + skid_valid; 2-bit, never 3.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- When defined, adds output ports stall_cnt[31:0] and flush_cnt[31:0]:
  - stall_cnt increments on every edge with out_valid=1 and out_ready=0.
  - flush_cnt increments on every edge with flush=1.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When not defined, the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset while FULL: preload 2 entries, rst_n=0 one edge -> occupancy=0, out_valid=0, in_ready=1, out_data=RESET_VAL.
- Streaming: in_valid=1 and out_ready=1 continuously, data 1..100 -> out_data 1..100 in order, one per edge after 1-edge latency, in_ready never 0.
- Stall/skid: out_ready=0 for 5 edges with in_valid=1, data A,B,C -> A and B held, occupancy=2, in_ready=0, C held upstream. Then out_ready=1 -> A, B, C emerge in order with no loss.
- Flush: FULL with KILL_MASK=6'b111111 on the control LSBs and entries 0x..3F, flush=1 with in_valid=1 -> next edge occupancy=0, out_valid=0, the new input is never output, stored control bits read 0.
- Flush plus out_ready in ONE: entry X present, flush=1 and out_ready=1 same edge -> X counted as delivered, state EMPTY.
- STATS: with PIPE_STAGE_STATS_EN, 7 stall edges and 2 flushes -> stall_cnt=7, flush_cnt=2. Preset the counter to 32'hFFFF_FFFE, stall 3 more edges -> stall_cnt=32'hFFFF_FFFF.
